// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } scan_state_t;

  localparam logic [3:0] COL_INIT = 4'b1110;

  // Physical layout: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
  function automatic logic [3:0] key_lut(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = '0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous active-low inputs; resets to all-ones (idle).
module keypad_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce and no-rollover key hold.
// Define KEYPAD_RELEASE_EN to add the one-cycle key_released strobe port.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS     = 24000,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic       internal_oscillator,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
`ifdef KEYPAD_RELEASE_EN
  ,
  output logic       key_released
`endif
);

  localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);

  logic [3:0]    rs;
  scan_state_t   state_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] db_cnt_q;
  logic [DW-1:0] db_inc;
  logic          db_done;
  logic          tick;
  logic [3:0]    columns_q;
  logic [1:0]    col_q;
  logic [1:0]    row_q;
  logic [1:0]    first_row;
  logic          first_found;
  logic [3:0]    key_code_q;
  logic          key_valid_q;
  logic          key_held_q;
`ifdef KEYPAD_RELEASE_EN
  logic          key_released_q;
`endif

  keypad_sync #(.WIDTH(4)) u_sync (
    .clk_i  (internal_oscillator),
    .rst_ni (reset),
    .d_i    (rows),
    .q_o    (rs)
  );

  assign tick       = (tick_cnt_q == TW'(SCAN_TICKS - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  // Debounce count saturates rather than wrapping.
  assign db_inc  = (db_cnt_q >= DW'(DEBOUNCE_TICKS)) ? DW'(DEBOUNCE_TICKS) : db_cnt_q + 1'b1;
  assign db_done = (db_inc == DW'(DEBOUNCE_TICKS));

  always_comb begin
    first_row   = '0;
    first_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rs[i] && !first_found) begin
        first_row   = 2'(i);
        first_found = 1'b1;
      end
    end
  end

  always_ff @(posedge internal_oscillator) begin
    if (!reset) begin
      state_q     <= SCAN;
      tick_cnt_q  <= '0;
      db_cnt_q    <= '0;
      columns_q   <= COL_INIT;
      col_q       <= '0;
      row_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_RELEASE_EN
      key_released_q <= 1'b0;
`endif
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_RELEASE_EN
      key_released_q <= 1'b0;
`endif
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (rs != 4'hF) begin
              row_q    <= first_row;
              db_cnt_q <= '0;
              state_q  <= PRESS_DB;
            end else begin
              columns_q <= {columns_q[2:0], columns_q[3]};
              col_q     <= col_q + 2'd1;
            end
          end
          PRESS_DB: begin
            if (!rs[row_q]) begin
              db_cnt_q <= db_inc;
              if (db_done) begin
                state_q     <= HELD;
                key_code_q  <= key_lut(row_q, col_q);
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end
            end else begin
              state_q   <= SCAN;
              columns_q <= {columns_q[2:0], columns_q[3]};
              col_q     <= col_q + 2'd1;
            end
          end
          HELD: begin
            // A single-tick debounce completes on the first high sample.
            if (rs[row_q]) begin
              if (DEBOUNCE_TICKS <= 1) begin
                state_q    <= SCAN;
                key_held_q <= 1'b0;
                columns_q  <= {columns_q[2:0], columns_q[3]};
                col_q      <= col_q + 2'd1;
`ifdef KEYPAD_RELEASE_EN
                key_released_q <= 1'b1;
`endif
              end else begin
                state_q  <= RELEASE_DB;
                db_cnt_q <= DW'(1);
              end
            end
          end
          RELEASE_DB: begin
            if (rs[row_q]) begin
              db_cnt_q <= db_inc;
              if (db_done) begin
                state_q    <= SCAN;
                key_held_q <= 1'b0;
                columns_q  <= {columns_q[2:0], columns_q[3]};
                col_q      <= col_q + 2'd1;
`ifdef KEYPAD_RELEASE_EN
                key_released_q <= 1'b1;
`endif
              end
            end else begin
              state_q <= HELD;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign columns   = columns_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
`ifdef KEYPAD_RELEASE_EN
  assign key_released = key_released_q;
`endif

endmodule
